quad_updn_ctr: RTL and testbench
================================

Name: quad_updn_ctr

Overview:
- Parametrised successor to the single up/down counter chips in the TTL library (169/191 style and the POTATO scroll counter).
- Holds NCH independent WIDTH-bit up/down counters, each driven by a quadrature pair.
- Provides an input synchroniser, a glitch filter, a x1/x4 decode mode, synchronous preload, an atomic snapshot latch and a sticky illegal-transition flag.
- Fills the 137304-1001 trackball interface slot and serves any future rotary or scroll counter.

Parameters:
- NCH, 2, number of independent counter channels (1..8)
- WIDTH, 8, counter width in bits (4..16)
- FILT, 2, number of consecutive stable ce samples needed to accept a new input level (1..15)
- X4, 1, 1 = count every quadrature edge; 0 = count only on a qa rising edge (x1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ce  in  1  sample/count enable; filter and decoder advance only when ce=1
- qa  in  NCH  quadrature phase A per channel (asynchronous)
- qb  in  NCH  quadrature phase B per channel (asynchronous)
- load_n  in  1  synchronous preload strobe, active low
- load_sel  in  3  channel index for preload
- load_val  in  WIDTH  preload value
- latch  in  1  snapshot strobe; copies all counters into hold registers
- rd_sel  in  3  channel index for readback
- rd_data  out  WIDTH  hold register of rd_sel (combinational mux)
- dir  out  NCH  last accepted direction per channel (1 = up)
- err  out  NCH  sticky illegal-transition flag per channel
- err_clr  in  1  clears all err bits

Behaviour:
- Reset (rst_n=0, asynchronous):
  - counters, hold registers, dir, err and filter counters go to 0.
  - Synchroniser and filtered-state registers go to 2'b00.
  - rd_data therefore reads 0.
- Synchroniser: qa and qb each pass through 2 flops on every clk, independent of ce.
- Glitch filter (per channel, per phase):
  - Runs only on ce cycles.
  - If the synced level differs from the accepted level, a stability counter increments; otherwise it clears.
  - When the counter reaches FILT, the new level is accepted and the counter clears.
  - FILT=1 means the level is accepted on the first differing ce sample.
- Decode on accepted state {A,B}, Gray order 00→01→11→10→00 = down, reverse order = up:
  - Single-bit change: one step, and dir updates.
  - Both bits change in one accept cycle: no count, err bit set, dir unchanged.
  - X4=0: count only on A 0→1. Up if B=0, down if B=1.
- Counter arithmetic: modulo 2^WIDTH. Up from all-ones wraps to 0; down from 0 wraps to all-ones. No saturation.
- Preload: load_n=0 writes load_val into counter[load_sel] at the next clk edge.
  - Load wins over a same-cycle step on that channel; the step is discarded.
  - Other channels count normally.
  - load_sel >= NCH is ignored.
- Snapshot: latch=1 copies every counter's pre-edge value into hold at the clk edge. This is atomic across channels.
  - If latch and preload occur together, hold gets the old value.
- Readback: rd_data = hold[rd_sel], zero-latency mux. rd_sel >= NCH returns 0.
- err_clr: clears all err bits at the clk edge. A simultaneous new illegal transition wins (bit stays 1).
- Latency: input edge to count = 2 sync clks + FILT ce samples + 1 clk.

Decomposition:
- Shared package qdec_pkg holds:
  - direction constants DIR_UP=1, DIR_DN=0
  - a 4x4 step-table function returning {valid, up, illegal} from the old and new 2-bit states
  - SYNC_STAGES=2
- One sub-module quad_chan per channel, instantiated NCH times by generate. It contains the synchroniser, the filter, the decode and the counter.
- The top level holds preload addressing, hold registers, the readback mux and the err_clr fan-out.

Test Plan:
- Reset: release rst_n with ce=1 and inputs 00 → rd_data=0, dir=0, err=0 for all channels. Assert rst_n mid-count → counters go to 0 immediately, without waiting for a clk.
- Up/down x4, FILT=2: drive ch0 through 00,10,11,01,00 with each level held 3 ce cycles, then latch → rd_data=4 (up), dir[0]=1. Reverse the sequence and latch → 0, dir[0]=0.
- Wrap: preload ch1 with 8'hFF, give one up step, latch, rd_sel=1 → 8'h00. Give one down step → 8'hFF.
- Glitch and illegal:
  - A 1-ce-sample pulse on qa with FILT=2 → no count.
  - 00→11 held stable → err[0]=1 and the count is unchanged.
  - err_clr → err[0]=0.
- Simultaneous events: preload ch0=8'h40 in the same cycle as a ch0 up step and a latch → hold keeps the old value. The next latch reads 8'h40, with no increment.
- X1 mode (X4=0): one full cycle forward → count +1. One full cycle backward → count −1.

Source files
------------

// File: rtl/qdec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : qdec_pkg
// Description : Shared constants and quadrature step table for quad_updn_ctr
// Revision    : 1.0 - initial release
// ============================================================================
package qdec_pkg;

    localparam logic DIR_UP      = 1'b1;
    localparam logic DIR_DN      = 1'b0;
    localparam int   SYNC_STAGES = 2;

    typedef struct packed {
        logic valid;
        logic up;
        logic illegal;
    } step_t;

    // Accepted state is {A,B}; 00->10->11->01->00 counts up, the reverse counts down.
    function automatic step_t step_lookup(input logic [1:0] old_s, input logic [1:0] new_s);
        step_t s;
        s = '0;
        case ({old_s, new_s})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: begin
                s.valid = 1'b1;
                s.up    = 1'b1;
            end
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: begin
                s.valid = 1'b1;
                s.up    = 1'b0;
            end
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: begin
                s.illegal = 1'b1;
            end
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/quad_chan.sv
`default_nettype none
// ============================================================================
// Module      : quad_chan
// Description : One quadrature channel: synchroniser, glitch filter, decoder, counter
// Revision    : 1.0 - initial release
// ============================================================================
module quad_chan
    import qdec_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int FILT  = 2,
    parameter int X4    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             qa,
    input  logic             qb,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             err_clr,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             err
);

    localparam logic [3:0] c_FILT_LAST = 4'(FILT - 1);

    logic [SYNC_STAGES-1:0] r_sync_a;
    logic [SYNC_STAGES-1:0] r_sync_b;
    logic [1:0]             w_synced;
    logic [1:0]             r_acc;
    logic [1:0]             r_prev;
    logic [3:0]             r_fcnt [2];
    logic [WIDTH-1:0]       r_count;
    logic                   r_dir;
    logic                   r_err;
    step_t                  w_step;
    logic                   w_cnt_en;
    logic                   w_up;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_a <= '0;
            r_sync_b <= '0;
        end else begin
            r_sync_a <= {r_sync_a[SYNC_STAGES-2:0], qa};
            r_sync_b <= {r_sync_b[SYNC_STAGES-2:0], qb};
        end
    end

    assign w_synced = {r_sync_a[SYNC_STAGES-1], r_sync_b[SYNC_STAGES-1]};

    // A differing level must be seen on FILT consecutive ce samples before it is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= 2'b00;
            for (int p = 0; p < 2; p++) r_fcnt[p] <= '0;
        end else if (ce) begin
            for (int p = 0; p < 2; p++) begin
                if (w_synced[p] != r_acc[p]) begin
                    if (r_fcnt[p] == c_FILT_LAST) begin
                        r_acc[p]  <= w_synced[p];
                        r_fcnt[p] <= '0;
                    end else begin
                        r_fcnt[p] <= r_fcnt[p] + 4'd1;
                    end
                end else begin
                    r_fcnt[p] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_prev <= 2'b00;
        else        r_prev <= r_acc;
    end

    assign w_step = step_lookup(r_prev, r_acc);

    generate
        if (X4 != 0) begin : g_x4
            assign w_cnt_en = w_step.valid;
            assign w_up     = w_step.up;
        end else begin : g_x1
            // Count on A rising only; B low at that moment means forward.
            assign w_cnt_en = w_step.valid && !r_prev[1] && r_acc[1];
            assign w_up     = !r_acc[0];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_dir   <= DIR_DN;
            r_err   <= 1'b0;
        end else begin
            if (load) begin
                r_count <= load_val;
            end else if (w_cnt_en) begin
                r_count <= w_up ? r_count + 1'b1 : r_count - 1'b1;
                r_dir   <= w_up ? DIR_UP : DIR_DN;
            end
            r_err <= (r_err & ~err_clr) | w_step.illegal;
        end
    end

    assign count = r_count;
    assign dir   = r_dir;
    assign err   = r_err;

endmodule
`default_nettype wire

// File: rtl/quad_updn_ctr.sv
`default_nettype none
// ============================================================================
// Module      : quad_updn_ctr
// Description : NCH-channel quadrature up/down counter with snapshot readback
// Revision    : 1.0 - initial release
// ============================================================================
module quad_updn_ctr
    import qdec_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int WIDTH = 8,
    parameter int FILT  = 2,
    parameter int X4    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic [NCH-1:0]   qa,
    input  logic [NCH-1:0]   qb,
    input  logic             load_n,
    input  logic [2:0]       load_sel,
    input  logic [WIDTH-1:0] load_val,
    input  logic             latch,
    input  logic [2:0]       rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic [NCH-1:0]   dir,
    output logic [NCH-1:0]   err,
    input  logic             err_clr
);

    logic [WIDTH-1:0] w_count [NCH];
    logic [WIDTH-1:0] r_hold  [NCH];

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_chan
            logic w_load;
            assign w_load = !load_n && (load_sel == 3'(i));

            quad_chan #(
                .WIDTH (WIDTH),
                .FILT  (FILT),
                .X4    (X4)
            ) u_chan (
                .clk      (clk),
                .rst_n    (rst_n),
                .ce       (ce),
                .qa       (qa[i]),
                .qb       (qb[i]),
                .load     (w_load),
                .load_val (load_val),
                .err_clr  (err_clr),
                .count    (w_count[i]),
                .dir      (dir[i]),
                .err      (err[i])
            );
        end
    endgenerate

    // All channels are captured on the same edge so a snapshot is coherent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) r_hold[i] <= '0;
        end else if (latch) begin
            for (int i = 0; i < NCH; i++) r_hold[i] <= w_count[i];
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (rd_sel == 3'(i)) rd_data = r_hold[i];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_quad_updn_ctr.sv
`default_nettype none
// ============================================================================
// Module      : tb_quad_updn_ctr
// Description : Self-checking bench for quad_updn_ctr in x4 and x1 decode modes
// Revision    : 1.0 - initial release
// ============================================================================
module tb_quad_updn_ctr;

    localparam int NCH   = 2;
    localparam int WIDTH = 8;
    localparam int HOLD  = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ce;
    logic [NCH-1:0]   qa;
    logic [NCH-1:0]   qb;
    logic             load_n;
    logic [2:0]       load_sel;
    logic [WIDTH-1:0] load_val;
    logic             latch;
    logic [2:0]       rd_sel;
    logic             err_clr;
    logic [WIDTH-1:0] rd_data4, rd_data1;
    logic [NCH-1:0]   dir4, dir1, err4, err1;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: gray position per channel and expected counter/flags.
    logic [1:0]       gray_seq [4];
    logic [1:0]       lvl [NCH];
    logic [WIDTH-1:0] m4 [NCH], m1 [NCH];
    logic             md4 [NCH], md1 [NCH], me4 [NCH], me1 [NCH];

    always #5 clk = ~clk;

    quad_updn_ctr #(.NCH(NCH), .WIDTH(WIDTH), .FILT(2), .X4(1)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .qa(qa), .qb(qb),
        .load_n(load_n), .load_sel(load_sel), .load_val(load_val),
        .latch(latch), .rd_sel(rd_sel), .rd_data(rd_data4),
        .dir(dir4), .err(err4), .err_clr(err_clr)
    );

    quad_updn_ctr #(.NCH(NCH), .WIDTH(WIDTH), .FILT(2), .X4(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .qa(qa), .qb(qb),
        .load_n(load_n), .load_sel(load_sel), .load_val(load_val),
        .latch(latch), .rd_sel(rd_sel), .rd_data(rd_data1),
        .dir(dir1), .err(err1), .err_clr(err_clr)
    );

    function automatic int pos(input logic [1:0] s);
        int r;
        r = 0;
        for (int k = 0; k < 4; k++) if (gray_seq[k] == s) r = k;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            lvl[c] = 2'b00; m4[c] = '0; m1[c] = '0;
            md4[c] = 1'b0; md1[c] = 1'b0; me4[c] = 1'b0; me1[c] = 1'b0;
        end
    endtask

    task automatic model_step(input int ch, input logic [1:0] nl);
        int d;
        d = (pos(nl) - pos(lvl[ch]) + 4) % 4;
        if (d == 1) begin m4[ch] = m4[ch] + 1'b1; md4[ch] = 1'b1; end
        if (d == 3) begin m4[ch] = m4[ch] - 1'b1; md4[ch] = 1'b0; end
        if (d == 2) begin me4[ch] = 1'b1; me1[ch] = 1'b1; end
        if (d != 2 && !lvl[ch][1] && nl[1]) begin
            if (!nl[0]) begin m1[ch] = m1[ch] + 1'b1; md1[ch] = 1'b1; end
            else        begin m1[ch] = m1[ch] - 1'b1; md1[ch] = 1'b0; end
        end
        lvl[ch] = nl;
    endtask

    task automatic drive(input int ch, input logic [1:0] nl);
        @(negedge clk);
        qa[ch] = nl[1];
        qb[ch] = nl[0];
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic apply(input int ch, input logic [1:0] nl);
        drive(ch, nl);
        model_step(ch, nl);
    endtask

    task automatic check_all(input string tag);
        @(negedge clk); latch = 1'b1;
        @(negedge clk); latch = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            rd_sel = 3'(c);
            #1;
            chk($sformatf("%s cnt4[%0d]", tag, c), rd_data4, m4[c]);
            chk($sformatf("%s cnt1[%0d]", tag, c), rd_data1, m1[c]);
            chk($sformatf("%s dir4[%0d]", tag, c), WIDTH'(dir4[c]), WIDTH'(md4[c]));
            chk($sformatf("%s dir1[%0d]", tag, c), WIDTH'(dir1[c]), WIDTH'(md1[c]));
            chk($sformatf("%s err4[%0d]", tag, c), WIDTH'(err4[c]), WIDTH'(me4[c]));
            chk($sformatf("%s err1[%0d]", tag, c), WIDTH'(err1[c]), WIDTH'(me1[c]));
        end
    endtask

    task automatic do_load(input logic [2:0] sel, input logic [WIDTH-1:0] val);
        @(negedge clk); load_n = 1'b0; load_sel = sel; load_val = val;
        @(negedge clk); load_n = 1'b1;
        if (sel < NCH) begin m4[sel] = val; m1[sel] = val; end
    endtask

    task automatic do_errclr();
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        for (int c = 0; c < NCH; c++) begin me4[c] = 1'b0; me1[c] = 1'b0; end
    endtask

    initial begin
        logic [1:0] nl;
        logic [WIDTH-1:0] old4, old1;
        int r;

        gray_seq[0] = 2'b00; gray_seq[1] = 2'b10; gray_seq[2] = 2'b11; gray_seq[3] = 2'b01;
        model_reset();
        rst_n = 1'b0; ce = 1'b1; qa = '0; qb = '0; load_n = 1'b1; load_sel = '0;
        load_val = '0; latch = 1'b0; rd_sel = '0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset rd_data", rd_data4, '0);
        chk("reset dir", WIDTH'(dir4), '0);
        chk("reset err", WIDTH'(err4 | err1), '0);
        check_all("reset");

        // Forward and reverse full cycles on channel 0.
        apply(0, 2'b10); apply(0, 2'b11); apply(0, 2'b01); apply(0, 2'b00);
        check_all("up");
        apply(0, 2'b01); apply(0, 2'b11); apply(0, 2'b10); apply(0, 2'b00);
        check_all("down");

        // Wrap in both directions on channel 1.
        do_load(3'd1, 8'hFF);
        apply(1, 2'b10);
        check_all("wrap up");
        apply(1, 2'b00);
        check_all("wrap down");

        // Out-of-range preload and readback select.
        do_load(3'd3, 8'h77);
        check_all("load oor");
        rd_sel = 3'd5; #1;
        chk("rd_sel oor", rd_data4, '0);

        // Single-sample glitch on qa must not be accepted.
        @(negedge clk); qa[0] = 1'b1;
        @(negedge clk); qa[0] = 1'b0;
        repeat (HOLD) @(negedge clk);
        check_all("glitch");

        // Illegal double-bit change, then clear.
        apply(0, 2'b11);
        check_all("illegal");
        do_errclr();
        check_all("errclr");
        apply(0, 2'b01); apply(0, 2'b00);
        check_all("recover");

        // Input held while ce is low is not counted until ce returns.
        ce = 1'b0;
        drive(0, 2'b10);
        check_all("ce off");
        ce = 1'b1;
        repeat (HOLD) @(negedge clk);
        model_step(0, 2'b10);
        check_all("ce on");

        // Preload, count step and latch all land on the same edge.
        nl = gray_seq[(pos(lvl[0]) + 1) % 4];
        old4 = m4[0]; old1 = m1[0];
        @(negedge clk);
        qa[0] = nl[1]; qb[0] = nl[0];
        repeat (4) @(posedge clk);
        @(negedge clk);
        load_n = 1'b0; load_sel = 3'd0; load_val = 8'h40; latch = 1'b1;
        @(negedge clk);
        load_n = 1'b1; latch = 1'b0; rd_sel = 3'd0;
        #1;
        chk("simul hold4", rd_data4, old4);
        chk("simul hold1", rd_data1, old1);
        lvl[0] = nl; m4[0] = 8'h40; m1[0] = 8'h40;
        repeat (HOLD) @(negedge clk);
        check_all("simul after");

        // Random walk with occasional illegal jumps, preloads and clears.
        for (int it = 0; it < 48; it++) begin
            int ch;
            ch = int'($urandom_range(0, NCH - 1));
            r  = int'($urandom_range(0, 9));
            if (r == 0)     nl = lvl[ch] ^ 2'b11;
            else if (r < 5) nl = gray_seq[(pos(lvl[ch]) + 1) % 4];
            else            nl = gray_seq[(pos(lvl[ch]) + 3) % 4];
            apply(ch, nl);
            if ($urandom_range(0, 5) == 0) do_load(3'($urandom_range(0, 3)), WIDTH'($urandom));
            if ($urandom_range(0, 7) == 0) do_errclr();
            if (it % 4 == 3) check_all($sformatf("rand%0d", it));
        end

        // Asynchronous reset mid-count clears without a clock edge.
        do_load(3'd0, 8'h5A);
        check_all("pre-reset");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        qa = '0; qb = '0;
        rd_sel = 3'd0;
        #1;
        chk("async rd_data", rd_data4, '0);
        chk("async dir", WIDTH'(dir4 | dir1), '0);
        chk("async err", WIDTH'(err4 | err1), '0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check_all("post-reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
